// File: rtl/breakout_play_ctrl.sv
// Breakout per-frame sequencer: owns ball/paddle positions and lives, and runs
// the serve / play / miss / game-over flow, stepping once per synchronized frame strobe.
module breakout_play_ctrl #(
  parameter int SCREEN_X_MAX = 639,
  parameter int SCREEN_Y_MAX = 479,
  parameter int BALL_SIZE    = 4,
  parameter int BAR_SIZE_X   = 32,
  parameter int BAR_SIZE_Y   = 4,
  parameter int BAR_Y        = 450,
  parameter int BALL_STEP    = 2,
  parameter int BAR_STEP     = 4,
  parameter int LIVES        = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       key_left,
  input  logic       key_right,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_size,
  output logic [9:0] BarX,
  output logic [9:0] BarY,
  output logic [9:0] Bar_Sizex,
  output logic [9:0] Bar_Sizey,
  output logic [1:0] lives,
  output logic [1:0] game_state,
  output logic       miss_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic signed [10:0] BALL_SIZE_S = 11'(BALL_SIZE);
  localparam logic signed [10:0] BALL_STEP_S = 11'(BALL_STEP);
  localparam logic signed [10:0] BAR_STEP_S  = 11'(BAR_STEP);
  localparam logic signed [10:0] X_MAX_S     = 11'(SCREEN_X_MAX);
  localparam logic signed [10:0] Y_MAX_S     = 11'(SCREEN_Y_MAX);
  localparam logic signed [10:0] BALL_X_HI_S = 11'(SCREEN_X_MAX - BALL_SIZE);
  localparam logic signed [10:0] BALL_Y_HI_S = 11'(SCREEN_Y_MAX - BALL_SIZE);
  localparam logic signed [10:0] BAR_MIN_S   = 11'(BAR_SIZE_X);
  localparam logic signed [10:0] BAR_MAX_S   = 11'(SCREEN_X_MAX - BAR_SIZE_X);
  localparam logic signed [10:0] BAR_Y_S     = 11'(BAR_Y);
  localparam logic signed [10:0] BAR_TOP_S   = 11'(BAR_Y - BAR_SIZE_Y);
  localparam logic signed [10:0] BAR_REACH_S = 11'(BAR_SIZE_X + BALL_SIZE);
  localparam logic [9:0]         CENTER_X    = 10'((SCREEN_X_MAX + 1) / 2);
  localparam logic [9:0]         PARK_Y      = 10'(BAR_Y - BAR_SIZE_Y - BALL_SIZE - 1);
  localparam logic [1:0]         LIVES_INIT  = 2'(LIVES);

  function automatic logic [9:0] clamp10(input logic signed [10:0] v,
                                         input logic signed [10:0] lo,
                                         input logic signed [10:0] hi);
    if (v < lo) begin
      clamp10 = lo[9:0];
    end else if (v > hi) begin
      clamp10 = hi[9:0];
    end else begin
      clamp10 = v[9:0];
    end
  endfunction

  logic       frame_meta_r, frame_sync_r, frame_prev_r, frame_tick_r;
  state_t     state_r;
  logic [9:0] ball_x_r, ball_y_r, bar_x_r;
  logic       vx_neg_r, vy_neg_r;
  logic [1:0] lives_r;
  logic       miss_pulse_r;

  logic signed [10:0] bx_s, by_s, bar_s, dx_s, abs_dx_s, bx_sum_s, by_sum_s, bar_sum_s;
  logic [9:0] bar_x_nxt_s, ball_x_nxt_s, ball_y_nxt_s;
  logic       hit_left_s, hit_right_s, hit_top_s, hit_bar_s;
  logic       vx_neg_nxt_s, vy_neg_nxt_s, miss_s;

  // Two-flop synchronizer on frame_clk followed by a registered rising-edge detect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_meta_r <= 1'b0;
      frame_sync_r <= 1'b0;
      frame_prev_r <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_meta_r <= frame_clk;
      frame_sync_r <= frame_meta_r;
      frame_prev_r <= frame_sync_r;
      frame_tick_r <= frame_sync_r & ~frame_prev_r;
    end
  end

  // Next paddle position, wall bounces, ball step and miss detection for one frame.
  always_comb begin
    bx_s      = signed'({1'b0, ball_x_r});
    by_s      = signed'({1'b0, ball_y_r});
    bar_s     = signed'({1'b0, bar_x_r});
    bar_sum_s = bar_s;
    if (key_left && !key_right) begin
      bar_sum_s = bar_s - BAR_STEP_S;
    end else if (key_right && !key_left) begin
      bar_sum_s = bar_s + BAR_STEP_S;
    end else begin
      bar_sum_s = bar_s;
    end
    bar_x_nxt_s = clamp10(bar_sum_s, BAR_MIN_S, BAR_MAX_S);

    dx_s        = bx_s - bar_s;
    abs_dx_s    = dx_s[10] ? -dx_s : dx_s;
    hit_left_s  = (bx_s <= BALL_SIZE_S) && vx_neg_r;
    hit_right_s = (bx_s + BALL_SIZE_S >= X_MAX_S) && !vx_neg_r;
    hit_top_s   = (by_s <= BALL_SIZE_S) && vy_neg_r;
    hit_bar_s   = !vy_neg_r && (by_s + BALL_SIZE_S >= BAR_TOP_S) &&
                  (by_s <= BAR_Y_S) && (abs_dx_s <= BAR_REACH_S);

    vx_neg_nxt_s = vx_neg_r;
    if (hit_left_s) begin
      vx_neg_nxt_s = 1'b0;
    end else if (hit_right_s) begin
      vx_neg_nxt_s = 1'b1;
    end else begin
      vx_neg_nxt_s = vx_neg_r;
    end
    vy_neg_nxt_s = vy_neg_r;
    if (hit_top_s) begin
      vy_neg_nxt_s = 1'b0;
    end else if (hit_bar_s) begin
      vy_neg_nxt_s = 1'b1;
    end else begin
      vy_neg_nxt_s = vy_neg_r;
    end

    bx_sum_s     = vx_neg_nxt_s ? (bx_s - BALL_STEP_S) : (bx_s + BALL_STEP_S);
    by_sum_s     = vy_neg_nxt_s ? (by_s - BALL_STEP_S) : (by_s + BALL_STEP_S);
    ball_x_nxt_s = clamp10(bx_sum_s, BALL_SIZE_S, BALL_X_HI_S);
    ball_y_nxt_s = clamp10(by_sum_s, BALL_SIZE_S, BALL_Y_HI_S);
    miss_s       = (signed'({1'b0, ball_y_nxt_s}) + BALL_SIZE_S >= Y_MAX_S);
  end

  // Game state machine; every game register changes only on a frame tick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r      <= ST_IDLE;
      ball_x_r     <= CENTER_X;
      ball_y_r     <= PARK_Y;
      bar_x_r      <= CENTER_X;
      vx_neg_r     <= 1'b0;
      vy_neg_r     <= 1'b1;
      lives_r      <= LIVES_INIT;
      miss_pulse_r <= 1'b0;
    end else begin
      miss_pulse_r <= 1'b0;
      if (frame_tick_r) begin
        case (state_r)
          ST_IDLE: begin
            bar_x_r  <= bar_x_nxt_s;
            ball_x_r <= bar_x_nxt_s;
            ball_y_r <= PARK_Y;
            vx_neg_r <= 1'b0;
            vy_neg_r <= 1'b1;
            state_r  <= start ? ST_PLAY : ST_IDLE;
          end
          ST_PLAY: begin
            bar_x_r  <= bar_x_nxt_s;
            ball_x_r <= ball_x_nxt_s;
            ball_y_r <= ball_y_nxt_s;
            vx_neg_r <= vx_neg_nxt_s;
            vy_neg_r <= vy_neg_nxt_s;
            // A miss overrides any paddle bounce; the ball is re-parked on the next IDLE tick.
            if (miss_s) begin
              miss_pulse_r <= 1'b1;
              lives_r      <= lives_r - 2'd1;
              state_r      <= (lives_r == 2'd1) ? ST_OVER : ST_IDLE;
            end else begin
              state_r <= ST_PLAY;
            end
          end
          ST_OVER: begin
            if (start) begin
              lives_r <= LIVES_INIT;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_OVER;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign BallX      = ball_x_r;
  assign BallY      = ball_y_r;
  assign BarX       = bar_x_r;
  assign lives      = lives_r;
  assign game_state = state_r;
  assign miss_pulse = miss_pulse_r;
  assign Ball_size  = 10'(BALL_SIZE);
  assign BarY       = 10'(BAR_Y);
  assign Bar_Sizex  = 10'(BAR_SIZE_X);
  assign Bar_Sizey  = 10'(BAR_SIZE_Y);

endmodule

// File: tb/tb_breakout_play_ctrl.sv
// Directed bench for breakout_play_ctrl: serve, paddle clamping, wall bounces,
// misses, game over and restart, with hand-computed trajectory checkpoints.
module tb_breakout_play_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n, frame_clk, start, key_left, key_right;
  logic [9:0] BallX, BallY, Ball_size, BarX, BarY, Bar_Sizex, Bar_Sizey;
  logic [1:0] lives, game_state;
  logic       miss_pulse;

  int n_cmp    = 0;
  int n_bad    = 0;
  int miss_cnt = 0;
  int base;

  breakout_play_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
    .key_left(key_left), .key_right(key_right),
    .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size), .BarX(BarX), .BarY(BarY),
    .Bar_Sizex(Bar_Sizex), .Bar_Sizey(Bar_Sizey), .lives(lives),
    .game_state(game_state), .miss_pulse(miss_pulse)
  );

  always #5 Clk = ~Clk;

  // Counts Clk cycles in which miss_pulse is high, sampled mid-cycle.
  always @(negedge Clk) begin
    if (miss_pulse === 1'b1) miss_cnt <= miss_cnt + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame strobe; returns after the update has settled.
  task automatic tick();
    frame_clk = 1'b1;
    repeat (5) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; start = 1'b0; key_left = 1'b0; key_right = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rst_ballx", BallX, 320);
    check_eq("rst_bally", BallY, 441);
    check_eq("rst_barx", BarX, 320);
    check_eq("rst_bary", BarY, 450);
    check_eq("rst_lives", lives, 3);
    check_eq("rst_state", game_state, 0);
    check_eq("rst_miss", miss_pulse, 0);
    check_eq("size_ball", Ball_size, 4);
    check_eq("size_barx", Bar_Sizex, 32);
    check_eq("size_bary", Bar_Sizey, 4);

    // Serve from reset: ball stays put on the start tick, moves on the next.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("serve_state", game_state, 1);
    check_eq("serve_ballx", BallX, 320);
    check_eq("serve_bally", BallY, 441);
    tick();
    check_eq("move1_ballx", BallX, 322);
    check_eq("move1_bally", BallY, 439);
    tick(); tick();
    check_eq("move3_ballx", BallX, 326);
    check_eq("move3_bally", BallY, 435);

    // Asynchronous reset mid-PLAY, checked before any clock edge.
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    check_eq("arst_ballx", BallX, 320);
    check_eq("arst_bally", BallY, 441);
    check_eq("arst_barx", BarX, 320);
    check_eq("arst_bary", BarY, 450);
    check_eq("arst_lives", lives, 3);
    check_eq("arst_state", game_state, 0);
    check_eq("arst_miss", miss_pulse, 0);
    #2 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // Paddle in IDLE drags the parked ball; right clamp; both keys hold.
    key_right = 1'b1;
    repeat (10) tick();
    check_eq("idle_barx10", BarX, 360);
    check_eq("idle_ballx10", BallX, 360);
    check_eq("idle_bally10", BallY, 441);
    repeat (90) tick();
    check_eq("clamp_barx", BarX, 607);
    check_eq("clamp_ballx", BallX, 607);
    key_left = 1'b1;
    repeat (3) tick();
    check_eq("both_barx", BarX, 607);
    key_left = 1'b0; key_right = 1'b0;

    // Launch from the right edge: right-wall and top bounces.
    start = 1'b1; tick(); start = 1'b0;
    check_eq("l1_state", game_state, 1);
    check_eq("l1_ballx", BallX, 607);
    key_left = 1'b1;
    repeat (14) tick();
    check_eq("rwall_ballx", BallX, 635);
    check_eq("rwall_bally", BallY, 413);
    tick();
    check_eq("rbounce_ballx", BallX, 633);
    check_eq("rbounce_bally", BallY, 411);
    for (int i = 0; i < 300 && BallY != 10'd4; i++) tick();
    check_eq("top_bally", BallY, 4);
    check_eq("top_ballx", BallX, 225);
    tick();
    check_eq("tbounce_bally", BallY, 6);
    check_eq("tbounce_ballx", BallX, 223);

    // Descent past the paddle parked at the left edge: first miss.
    base = miss_cnt;
    for (int i = 0; i < 400 && miss_cnt == base; i++) tick();
    check_eq("miss1_pulses", miss_cnt - base, 1);
    check_eq("miss1_bally", BallY, 475);
    check_eq("miss1_ballx", BallX, 254);
    check_eq("miss1_lives", lives, 2);
    check_eq("miss1_state", game_state, 0);
    check_eq("miss1_barx", BarX, 32);
    tick();
    check_eq("repark_bally", BallY, 441);
    check_eq("repark_ballx", BallX, 32);
    check_eq("repark_state", game_state, 0);
    check_eq("repark_pulses", miss_cnt - base, 1);

    // Two more serves from BarX=32, each ending in a miss.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; tick(); start = 1'b0;
      check_eq("relaunch_state", game_state, 1);
      base = miss_cnt;
      for (int i = 0; i < 600 && miss_cnt == base; i++) tick();
      check_eq("missk_pulses", miss_cnt - base, 1);
      check_eq("missk_lives", lives, 1 - k);
      check_eq("missk_ballx", BallX, 329);
      check_eq("missk_bally", BallY, 475);
      check_eq("missk_state", game_state, (k == 0) ? 0 : 2);
    end

    // Game over: everything frozen, start between ticks ignored, start at a tick restarts.
    key_left = 1'b0; key_right = 1'b1;
    repeat (3) tick();
    check_eq("over_barx", BarX, 32);
    check_eq("over_ballx", BallX, 329);
    check_eq("over_bally", BallY, 475);
    check_eq("over_state", game_state, 2);
    key_right = 1'b0;
    start = 1'b1;
    repeat (4) @(posedge Clk);
    #1 start = 1'b0;
    tick();
    check_eq("gap_state", game_state, 2);
    check_eq("gap_lives", lives, 0);
    start = 1'b1; tick(); start = 1'b0;
    check_eq("restart_state", game_state, 0);
    check_eq("restart_lives", lives, 3);
    tick();
    check_eq("restart_ballx", BallX, 32);
    check_eq("restart_bally", BallY, 441);
    check_eq("total_misses", miss_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
